// File: rtl/frame_scan_sequencer.sv
// Raster scan sequencer: walks one stored frame out of the frame memory and
// emits vsync/hsync/de/data with the 1-cycle memory read latency absorbed.
module frame_scan_sequencer #(
  parameter int DATA_WIDTH = 24,
  parameter int HRES       = 320,
  parameter int VRES       = 240,
  parameter int HSW        = 8,
  parameter int HBP        = 16,
  parameter int HFP        = 16,
  parameter int VSW        = 2,
  parameter int VBP        = 4,
  parameter int VFP        = 4,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_continuous,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_vsync,
  output logic                  o_hsync,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int HTOTAL = HSW + HBP + HRES + HFP;
  localparam int VTOTAL = VSW + VBP + VRES + VFP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(HSW);
  localparam logic [HW-1:0] H_ACT_BEG  = HW'(HSW + HBP);
  localparam logic [HW-1:0] H_ACT_END  = HW'(HSW + HBP + HRES);
  localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(VSW);
  localparam logic [VW-1:0] V_ACT_BEG  = VW'(VSW + VBP);
  localparam logic [VW-1:0] V_ACT_END  = VW'(VSW + VBP + VRES);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state, state_next;
  logic [HW-1:0]   h_cnt, h_next;
  logic [VW-1:0]   v_cnt, v_next;
  logic            last_count;
  logic            scanning;
  logic            hs0, vs0, act0;
  logic            de_q;
  logic            frame_end;

  assign scanning   = (state == SCAN);
  assign last_count = scanning && (h_cnt == H_LAST) && (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_next;
      h_cnt <= h_next;
      v_cnt <= v_next;
    end
  end

  // frame_end marks the last output-stage cycle; a start landing there is dropped
  always_comb begin
    state_next = state;
    h_next     = h_cnt;
    v_next     = v_cnt;
    case (state)
      IDLE: begin
        h_next = '0;
        v_next = '0;
        if (i_start && !frame_end) state_next = SCAN;
      end
      SCAN: begin
        if (last_count) begin
          h_next = '0;
          v_next = '0;
          if (!i_continuous) state_next = IDLE;
        end else if (h_cnt == H_LAST) begin
          h_next = '0;
          v_next = v_cnt + VW'(1);
        end else begin
          h_next = h_cnt + HW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign hs0  = scanning && (h_cnt < H_SYNC_END);
  assign vs0  = scanning && (v_cnt < V_SYNC_END);
  assign act0 = scanning && (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END)
                         && (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vsync   <= 1'b0;
      o_hsync   <= 1'b0;
      de_q      <= 1'b0;
      frame_end <= 1'b0;
      o_rd_addr <= '0;
    end else begin
      o_vsync   <= vs0;
      o_hsync   <= hs0;
      de_q      <= act0;
      frame_end <= last_count;
      if (!scanning || last_count)
        o_rd_addr <= '0;
      else if (act0)
        o_rd_addr <= o_rd_addr + ADDR_WIDTH'(1);
    end
  end

  // The memory's own output register is the data stage, so gating with de_q keeps it aligned
  assign o_rd_en      = act0;
  assign o_de         = de_q;
  assign o_data       = de_q ? i_rd_data : '0;
  assign o_frame_done = frame_end;
  assign o_busy       = scanning || frame_end;

endmodule

// File: tb/tb_frame_scan_sequencer.sv
// Directed bench for frame_scan_sequencer on a tiny 4x2 raster (HTOTAL=7, VTOTAL=5)
// with a synchronous memory model that returns data equal to the address.
module tb_frame_scan_sequencer;

  localparam int DW = 24;
  localparam int AW = 17;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          continuous;
  logic          busy;
  logic          frame_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          vsync;
  logic          hsync;
  logic          de;
  logic [DW-1:0] data;

  int checks   = 0;
  int failures = 0;
  int done_seen;

  frame_scan_sequencer #(
    .DATA_WIDTH(DW), .HRES(4), .VRES(2),
    .HSW(1), .HBP(1), .HFP(1),
    .VSW(1), .VBP(1), .VFP(1),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(start),
    .i_continuous(continuous),
    .o_busy(busy),
    .o_frame_done(frame_done),
    .o_rd_en(rd_en),
    .o_rd_addr(rd_addr),
    .i_rd_data(rd_data),
    .o_vsync(vsync),
    .o_hsync(hsync),
    .o_de(de),
    .o_data(data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial rd_data = '0;
  always @(posedge clk) if (rd_en) rd_data <= DW'(rd_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkVal(tag, {busy, frame_done, rd_en, rd_addr, vsync, hsync, de, data}, 64'd0);
  endtask

  // Hand-derived expectations for frame cycle k (0..34) of the 7x5 raster
  task automatic checkOutput(input int k, input bit exp_done);
    int e_en, e_addr, e_de, e_data, e_hs, e_vs;
    e_en   = ((k >= 16 && k <= 19) || (k >= 23 && k <= 26)) ? 1 : 0;
    e_addr = (k <= 16) ? 0 : (k <= 20) ? k - 16 : (k <= 23) ? 4 : (k <= 27) ? k - 19 : 8;
    e_de   = ((k >= 17 && k <= 20) || (k >= 24 && k <= 27)) ? 1 : 0;
    e_data = (e_de == 0) ? 0 : (k <= 20) ? k - 17 : k - 20;
    e_hs   = (k >= 1 && ((k - 1) % 7) == 0) ? 1 : 0;
    e_vs   = (k >= 1 && k <= 7) ? 1 : 0;
    checkVal($sformatf("rd_en@%0d", k),   64'(rd_en),   64'(e_en));
    checkVal($sformatf("rd_addr@%0d", k), 64'(rd_addr), 64'(e_addr));
    checkVal($sformatf("de@%0d", k),      64'(de),      64'(e_de));
    checkVal($sformatf("data@%0d", k),    64'(data),    64'(e_data));
    checkVal($sformatf("hsync@%0d", k),   64'(hsync),   64'(e_hs));
    checkVal($sformatf("vsync@%0d", k),   64'(vsync),   64'(e_vs));
    checkVal($sformatf("busy@%0d", k),    64'(busy),    64'd1);
    checkVal($sformatf("done@%0d", k),    64'(frame_done), 64'(exp_done));
  endtask

  task automatic applyStimulus(input bit s, input bit c);
    start      = s;
    continuous = c;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    #2;
    checkIdle("reset_hold");
    repeat (3) step();
    rst_n = 1'b1;
    $display("[TB] idle after reset");
    for (int i = 0; i < 100; i++) begin
      step();
      checkIdle($sformatf("idle@%0d", i));
    end

    $display("[TB] single frame");
    applyStimulus(1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0);
    for (int k = 0; k < 35; k++) begin
      checkOutput(k, 1'b0);
      step();
    end
    checkOutput(0, 1'b1);
    step();
    checkIdle("single_end");

    $display("[TB] continuous, three frames");
    done_seen = 0;
    applyStimulus(1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b1);
    for (int g = 0; g < 105; g++) begin
      if (g == 80) applyStimulus(1'b0, 1'b0);
      checkOutput(g % 35, (g >= 35) && (g % 35 == 0));
      if (frame_done) done_seen++;
      step();
    end
    checkOutput(0, 1'b1);
    if (frame_done) done_seen++;
    step();
    checkIdle("cont_end");
    checkVal("cont_done_count", 64'(done_seen), 64'd3);

    $display("[TB] start while busy and on done cycle");
    applyStimulus(1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0);
    for (int k = 0; k < 35; k++) begin
      applyStimulus(k == 10, 1'b0);
      checkOutput(k, 1'b0);
      step();
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput(0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkIdle($sformatf("no_requeue@%0d", i));
      step();
    end

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0);
    for (int k = 0; k <= 20; k++) begin
      checkOutput(k, 1'b0);
      if (k < 20) step();
    end
    rst_n = 1'b0;
    #1;
    checkIdle("async_reset");
    for (int i = 0; i < 5; i++) begin
      step();
      checkIdle($sformatf("in_reset@%0d", i));
    end
    rst_n = 1'b1;
    step();
    checkIdle("after_release");
    applyStimulus(1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0);
    for (int k = 0; k < 35; k++) begin
      checkOutput(k, 1'b0);
      step();
    end
    checkOutput(0, 1'b1);
    step();
    checkIdle("post_reset_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
